// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: receive-side 8N1 frame controller.
// Drives the sample counter enable, detects the start bit, samples each bit
// at mid-period, assembles the character LSB first and strobes it out.
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int MID_SAMPLE  = 7,
  parameter int LAST_SAMPLE = 15
) (
  input  logic                 Clock,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic [3:0]           bsc,
  output logic                 enable,
  output logic [DATA_BITS-1:0] char_out,
  output logic                 char_ready,
  output logic                 framing_err
);

  localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);
  localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_CNT = 4'(LAST_SAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic                 enable_n;
  logic [IDXW-1:0]      bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] char_out_n;
  logic                 char_ready_n;
  logic                 framing_err_n;
  logic                 at_mid, at_last;

  assign at_mid  = (bsc == MID_CNT);
  assign at_last = (bsc == LAST_CNT);

  // State and output registers; reset aborts any frame without pulses.
  always_ff @(posedge Clock) begin
    if (rst) begin
      state       <= IDLE;
      enable      <= 1'b0;
      bit_idx     <= '0;
      shreg       <= '0;
      char_out    <= '0;
      char_ready  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      enable      <= enable_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      char_out    <= char_out_n;
      char_ready  <= char_ready_n;
      framing_err <= framing_err_n;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_n       = state;
    enable_n      = enable;
    bit_idx_n     = bit_idx;
    shreg_n       = shreg;
    char_out_n    = char_out;
    char_ready_n  = 1'b0;
    framing_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!data_in) begin
          state_n  = START;
          enable_n = 1'b1;
        end
      end
      START: begin
        if (at_mid && data_in) begin
          state_n  = IDLE;
          enable_n = 1'b0;
        end else if (at_last) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (at_mid) begin
          shreg_n = {data_in, shreg[DATA_BITS-1:1]};
        end
        if (at_last) begin
          if (bit_idx == LAST_IDX) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + IDXW'(1);
          end
        end
      end
      STOP: begin
        if (at_mid) begin
          enable_n = 1'b0;
          if (data_in) begin
            char_out_n   = shreg;
            char_ready_n = 1'b1;
            state_n      = IDLE;
          end else begin
            framing_err_n = 1'b1;
            state_n       = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (data_in) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        enable_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench for the UART receive frame controller.
// The bench models the sample counter, drives 16-clock bit cells, and predicts
// each frame's outcome (good char / framing error) and the cycle it appears.
module tb_uart_rx_frame_ctrl;

  localparam int MID  = 7;
  localparam int LAST = 15;
  // Edges from the start-detect edge to the edge that samples the stop bit:
  // nine full bit cells, then the counter must reach MID and be sampled.
  localparam int STOP_LAT = 9 * (LAST + 1) + MID + 1;

  logic       Clock = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b1;
  logic [3:0] bsc = '0;
  logic       enable;
  logic [7:0] char_out;
  logic       char_ready;
  logic       framing_err;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  logic [7:0] last_good = '0;

  typedef struct {
    int         due;
    bit         good;
    logic [7:0] data;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  uart_rx_frame_ctrl #(
    .DATA_BITS  (8),
    .MID_SAMPLE (MID),
    .LAST_SAMPLE(LAST)
  ) dut (
    .Clock      (Clock),
    .rst        (rst),
    .data_in    (data_in),
    .bsc        (bsc),
    .enable     (enable),
    .char_out   (char_out),
    .char_ready (char_ready),
    .framing_err(framing_err)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // BitSampleCount_Receive behaviour: clear while disabled, else count and wrap.
  always @(posedge Clock) bsc <= enable ? bsc + 4'd1 : 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every pulse must match the oldest predicted frame outcome.
  always @(negedge Clock) begin
    if (!rst && (char_ready || framing_err)) begin
      check("pulse_exclusive", {31'd0, char_ready & framing_err}, 0);
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: char_ready=%b framing_err=%b at cycle %0d, want no pulse",
                 char_ready, framing_err, cyc);
      end else begin
        mon_e = expq.pop_front();
        check("pulse_time", cyc, mon_e.due);
        check("pulse_kind_ready", {31'd0, char_ready}, {31'd0, mon_e.good});
        if (mon_e.good) begin
          check("char_out_new", {24'd0, char_out}, {24'd0, mon_e.data});
          last_good = mon_e.data;
        end else begin
          check("char_out_hold", {24'd0, char_out}, {24'd0, last_good});
        end
      end
    end
  end

  task automatic do_reset(input logic line);
    data_in = line;
    rst = 1'b1;
    tick(2);
    check("rst_enable", {31'd0, enable}, 0);
    check("rst_char_out", {24'd0, char_out}, 0);
    check("rst_char_ready", {31'd0, char_ready}, 0);
    check("rst_framing_err", {31'd0, framing_err}, 0);
    rst = 1'b0;
    data_in = 1'b1;
    last_good = '0;
    tick(2);
  endtask

  // Called at a negedge with the DUT idle; the following posedge is the start edge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int abort_bit,
                            input int hold_low);
    exp_t e;
    data_in = 1'b0;
    if (abort_bit < 0) begin
      e.due  = cyc + 1 + STOP_LAT;
      e.good = stopb;
      e.data = d;
      expq.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      tick(16);
      data_in = d[i];
      if (i == abort_bit) begin
        tick(8);
        do_reset(1'b1);
        return;
      end
    end
    tick(16);
    data_in = stopb;
    tick(9);
    if (!stopb) begin
      for (int j = 0; j < hold_low; j++) begin
        check("wait_high_enable", {31'd0, enable}, 0);
        tick(1);
      end
      data_in = 1'b1;
      tick(1);
    end
  endtask

  task automatic glitch(input int len);
    data_in = 1'b0;
    tick(len);
    data_in = 1'b1;
    tick(8 - len);
    check("glitch_enable_high", {31'd0, enable}, 1);
    tick(1);
    check("glitch_enable_low", {31'd0, enable}, 0);
    check("glitch_char_hold", {24'd0, char_out}, {24'd0, last_good});
  endtask

  initial begin
    int r;
    do_reset(1'b1);
    do_reset(1'b0);

    send_frame(8'hA5, 1'b1, -1, 0);
    tick(5);
    glitch(3);
    tick(3);
    send_frame(8'h3C, 1'b0, -1, 40);
    tick(3);
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    tick(3);
    send_frame(8'h11, 1'b1, 4, 0);
    send_frame(8'h5A, 1'b1, -1, 0);
    tick(3);
    check("char_after_abort", {24'd0, char_out}, 32'h5A);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) glitch($urandom_range(1, 7));
      else send_frame(8'($urandom), (r != 2), -1, $urandom_range(0, 30));
      tick($urandom_range(0, 5));
    end

    tick(20);
    check("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
